hilo_arbiter: RTL and testbench
===============================

# hilo_arbiter

Owns the architectural HI/LO register pair and arbitrates writes to it between the WB stage (the HI/LO outputs of the MEM/WB pipeline register) and the multi-cycle divider. WB writes cannot be back-pressured and always win. Divider results are parked in a one-entry buffer and committed on the first free cycle. If the divider is blocked too long, the block raises a pipeline stall request to force a WB bubble. The block sits beside the register file at the end of the pipeline and drives the HI/LO read values back to the EX stage.

## Interface

- WIDTH, 32, width of HI and of LO
- MAX_WAIT, 4, consecutive blocked cycles tolerated before stall is requested (≥1)

- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-low reset
- wb_whilo  input  1  WB stage writes HI/LO this cycle
- wb_hi  input  WIDTH  WB HI value
- wb_lo  input  WIDTH  WB LO value
- div_valid  input  1  divider presents a result
- div_hi  input  WIDTH  remainder → HI
- div_lo  input  WIDTH  quotient → LO
- div_ready  output  1  buffer can accept a divider result; transfer when div_valid && div_ready
- hi_o  output  WIDTH  current HI (registered)
- lo_o  output  WIDTH  current LO (registered)
- stallreq  output  1  registered request to pipeline control to insert a WB bubble
- busy  output  1  buffer holds an uncommitted divider result

## Operation

- Storage: hi_r, lo_r, buffer (buf_hi, buf_lo, buf_valid), wait_cnt (clog2(MAX_WAIT+1) bits), state.
- div_ready = !buf_valid. This is combinational from registered state only and never depends on div_valid. busy = buf_valid.
- Accept: on a div_valid && div_ready edge, the buffer loads div_hi/div_lo and buf_valid←1.
- Commit priority per cycle:
  - wb_whilo=1: hi_r/lo_r ← wb_hi/wb_lo. If buf_valid, this is a blocked cycle.
  - wb_whilo=0 and buf_valid: hi_r/lo_r ← buffer, buf_valid←0, wait_cnt←0.
  - Otherwise: hold.
- A result accepted in cycle N cannot commit in cycle N. The buffer is not bypassed into HI/LO.
- States:
  - IDLE: buffer empty. On accept → PEND.
  - PEND: buffer full, stallreq=0.
    - Commit → IDLE.
    - Blocked cycle: wait_cnt+1. If this blocked cycle is the MAX_WAIT-th → STALL, stallreq←1.
  - STALL: stallreq=1. Pipeline control guarantees wb_whilo=0 from the cycle after stallreq rises, but an in-flight WB write may still win in the first STALL cycle. Commit → IDLE and stallreq←0 on that edge.
- Accept and commit never coincide, because div_ready=0 whenever buf_valid=1. Back-to-back divider results are therefore spaced ≥2 cycles.
- wait_cnt saturates at MAX_WAIT and is cleared on commit and on reset.

## Timing

- Reset (rst=0 at an edge):
  - hi_o=0, lo_o=0, stallreq=0, busy=0, div_ready=1, state IDLE, wait_cnt=0.
  - A buffered result is discarded. A reset mid-STALL drops stallreq on the next edge.
- WB write latency: hi_o/lo_o update on the edge ending the wb_whilo cycle (1 cycle).
- Divider latency, unblocked: accepted at edge E, committed at edge E+1, visible on hi_o/lo_o after E+1.
- Divider latency, blocked: the stall is requested after MAX_WAIT consecutive blocked cycles. Commit occurs at most 2 cycles after stallreq rises, given the pipeline contract.
- stallreq is high only in STALL and never glitches. It falls on the same edge the buffer commits.
- WB write and buffer commit in the same cycle: WB wins, the buffer is retained, and the cycle counts as blocked.

## Test plan

- Reset: drive rst=0 for 2 cycles with wb_whilo=1 and div_valid=1. Required: hi_o=lo_o=0, div_ready=1, stallreq=0, busy=0.
- WB only: wb_whilo=1, wb_hi=0x12345678, wb_lo=0x9ABCDEF0 for one cycle. Required: hi_o/lo_o show those values the next cycle.
- Divider unblocked: div_valid=1, div_hi=0x3, div_lo=0x7 with wb_whilo=0. Required:
  - div_ready drops the next cycle.
  - hi_o=0x3, lo_o=0x7 one cycle later.
  - div_ready returns to 1.
- Collision: accept div (0xA/0xB), then hold wb_whilo=1 with wb_hi=0x1 for 2 cycles, then wb_whilo=0. Required:
  - hi_o=0x1 during the WB cycles.
  - Then hi_o=0xA, lo_o=0xB.
  - stallreq never asserts.
- Starvation (MAX_WAIT=4): accept a div result, then hold wb_whilo=1 for 6 cycles. Required:
  - stallreq rises after the 4th blocked cycle.
  - It stays high until the first wb_whilo=0 cycle, whose edge commits the buffer and clears stallreq.
- Reset mid-STALL: apply rst=0 while stallreq=1 and busy=1. Required: the next cycle shows stallreq=0, busy=0, hi_o=lo_o=0, and the buffered result is never committed.

Source files
------------

// File: rtl/hilo_arbiter.sv
// HI/LO register pair with WB-vs-divider write arbitration; WB writes land in 1 cycle, a parked divider result commits on the first WB-free cycle.
// Divider is back-pressured via div_ready (one-entry buffer); prolonged blocking raises a registered stallreq to force a WB bubble.
module hilo_arbiter #(
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_whilo,
    input  logic [WIDTH-1:0] wb_hi,
    input  logic [WIDTH-1:0] wb_lo,
    input  logic             div_valid,
    input  logic [WIDTH-1:0] div_hi,
    input  logic [WIDTH-1:0] div_lo,
    output logic             div_ready,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             stallreq,
    output logic             busy
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX  = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_STALL = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] buf_hi_q, buf_hi_d;
    logic [WIDTH-1:0] buf_lo_q, buf_lo_d;
    logic             buf_vld_q, buf_vld_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             stall_q, stall_d;

    logic accept;
    logic commit;
    logic blocked;

    // Ready comes only from registered state, so accept and commit are mutually exclusive.
    assign div_ready = !buf_vld_q;
    assign accept    = div_valid && !buf_vld_q;
    assign commit    = buf_vld_q && !wb_whilo;
    assign blocked   = buf_vld_q && wb_whilo;

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        buf_hi_d   = buf_hi_q;
        buf_lo_d   = buf_lo_q;
        buf_vld_d  = buf_vld_q;
        wait_cnt_d = wait_cnt_q;
        stall_d    = stall_q;

        if (wb_whilo) begin
            hi_d = wb_hi;
            lo_d = wb_lo;
        end else if (commit) begin
            hi_d = buf_hi_q;
            lo_d = buf_lo_q;
        end

        if (accept) begin
            buf_hi_d  = div_hi;
            buf_lo_d  = div_lo;
            buf_vld_d = 1'b1;
        end

        if (commit) begin
            buf_vld_d  = 1'b0;
            wait_cnt_d = '0;
        end else if (blocked && (wait_cnt_q != WAIT_MAX)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (commit) begin
                    state_d = ST_IDLE;
                end else if (blocked && (wait_cnt_q == WAIT_LAST)) begin
                    state_d = ST_STALL;
                    stall_d = 1'b1;
                end
            end
            ST_STALL: begin
                // An in-flight WB write may still win here; stay until the buffer drains.
                if (commit) begin
                    state_d = ST_IDLE;
                    stall_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                stall_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            buf_hi_q   <= '0;
            buf_lo_q   <= '0;
            buf_vld_q  <= 1'b0;
            wait_cnt_q <= '0;
            stall_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            buf_hi_q   <= buf_hi_d;
            buf_lo_q   <= buf_lo_d;
            buf_vld_q  <= buf_vld_d;
            wait_cnt_q <= wait_cnt_d;
            stall_q    <= stall_d;
        end
    end

    assign hi_o     = hi_q;
    assign lo_o     = lo_q;
    assign stallreq = stall_q;
    assign busy     = buf_vld_q;

endmodule

// File: tb/tb_hilo_arbiter.sv
// Scoreboard bench for hilo_arbiter: directed scenarios then random traffic against a queue-based reference model.
module tb_hilo_arbiter;

    localparam int WIDTH    = 32;
    localparam int MAX_WAIT = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             wb_whilo;
    logic [WIDTH-1:0] wb_hi;
    logic [WIDTH-1:0] wb_lo;
    logic             div_valid;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;
    logic             div_ready;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic             stallreq;
    logic             busy;

    hilo_arbiter #(.WIDTH(WIDTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_whilo  (wb_whilo),
        .wb_hi     (wb_hi),
        .wb_lo     (wb_lo),
        .div_valid (div_valid),
        .div_hi    (div_hi),
        .div_lo    (div_lo),
        .div_ready (div_ready),
        .hi_o      (hi_o),
        .lo_o      (lo_o),
        .stallreq  (stallreq),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
        logic             stall;
        logic             busy;
        logic             rdy;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: architectural HI/LO, a queue of parked divider results,
    // and a count of consecutive cycles the parked result lost to WB.
    logic [WIDTH-1:0]   m_hi = '0;
    logic [WIDTH-1:0]   m_lo = '0;
    logic [2*WIDTH-1:0] m_pend[$];
    int                 m_blocked = 0;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic [WIDTH-1:0] whi,
                        input logic [WIDTH-1:0] wlo, input logic dv,
                        input logic [WIDTH-1:0] dhi, input logic [WIDTH-1:0] dlo);
        bit   was_empty;
        exp_t e;
        @(negedge clk);
        rst       = r;
        wb_whilo  = w;
        wb_hi     = whi;
        wb_lo     = wlo;
        div_valid = dv;
        div_hi    = dhi;
        div_lo    = dlo;
        if (!r) begin
            m_hi = '0;
            m_lo = '0;
            m_pend.delete();
            m_blocked = 0;
        end else begin
            was_empty = (m_pend.size() == 0);
            if (w) begin
                m_hi = whi;
                m_lo = wlo;
                if (!was_empty && m_blocked < MAX_WAIT) m_blocked++;
            end else if (!was_empty) begin
                {m_hi, m_lo} = m_pend.pop_front();
                m_blocked = 0;
            end
            if (was_empty && dv) m_pend.push_back({dhi, dlo});
        end
        e.hi    = m_hi;
        e.lo    = m_lo;
        e.stall = (m_blocked >= MAX_WAIT);
        e.busy  = (m_pend.size() != 0);
        e.rdy   = (m_pend.size() == 0);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic wb(input int n, input logic [WIDTH-1:0] h, input logic [WIDTH-1:0] l);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, h, l, 1'b0, '0, '0);
    endtask

    // Monitor: each cycle the DUT presents a fresh registered state one step after the edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("hi_o", hi_o, e.hi);
                chk("lo_o", lo_o, e.lo);
                chk("stallreq", WIDTH'(stallreq), WIDTH'(e.stall));
                chk("busy", WIDTH'(busy), WIDTH'(e.busy));
                chk("div_ready", WIDTH'(div_ready), WIDTH'(e.rdy));
            end
        end
    end

    initial begin : stim
        int pw;
        rst = 1'b0; wb_whilo = 1'b0; wb_hi = '0; wb_lo = '0;
        div_valid = 1'b0; div_hi = '0; div_lo = '0;

        // Reset with both write sources active
        for (int i = 0; i < 2; i++)
            step(1'b0, 1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 32'h55, 32'h66);
        idle(1);

        // WB only
        wb(1, 32'h1234_5678, 32'h9ABC_DEF0);
        idle(1);

        // Divider unblocked
        step(1'b1, 1'b0, '0, '0, 1'b1, 32'h3, 32'h7);
        idle(2);

        // Collision: WB wins twice, then the buffer commits
        step(1'b1, 1'b0, '0, '0, 1'b1, 32'hA, 32'hB);
        wb(2, 32'h1, 32'h2);
        idle(2);

        // Starvation: stallreq after the 4th blocked cycle, clears on commit
        step(1'b1, 1'b0, '0, '0, 1'b1, 32'hC0, 32'hC1);
        wb(6, 32'h11, 32'h22);
        idle(2);

        // Reset while stalled discards the parked result
        step(1'b1, 1'b0, '0, '0, 1'b1, 32'hE0, 32'hE1);
        wb(MAX_WAIT, 32'h33, 32'h44);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        idle(3);

        // Divider offered while busy must not be taken
        step(1'b1, 1'b1, 32'h5, 32'h6, 1'b1, 32'h70, 32'h71);
        step(1'b1, 1'b1, 32'h7, 32'h8, 1'b1, 32'h80, 32'h81);
        idle(2);

        // Random traffic with alternating WB pressure
        for (int i = 0; i < 1500; i++) begin
            pw = ((i / 100) % 2 == 0) ? 45 : 85;
            step(($urandom_range(0, 149) != 0),
                 ($urandom_range(0, 99) < pw),
                 $urandom, $urandom,
                 ($urandom_range(0, 1) == 1),
                 $urandom, $urandom);
        end
        idle(2);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
